// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone interconnect slice.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } wb_state_t;

  // Width of a slave index; a single slave still gets a 1-bit index.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Combinational address decoder: the lowest-index slave whose base matches
// the upper address bits wins.
module wb_addr_decoder
  import wb_pkg::*;
#(
  parameter int SLAVES     = 2,
  parameter int BASE_WIDTH = 24,
  parameter int IDX_WIDTH  = clog2(SLAVES)
) (
  input  logic [BASE_WIDTH-1:0]             page,
  input  logic [SLAVES-1:0][BASE_WIDTH-1:0] slave_base,
  output logic                              hit,
  output logic [IDX_WIDTH-1:0]              idx
);

  // Scanning downwards lets the lowest matching index overwrite the others.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if (page == slave_base[i]) begin
        hit = 1'b1;
        idx = IDX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/wb_interconnect.sv
// Single-master, multi-slave classic Wishbone interconnect with registered
// request/response paths. Optional BUSY timeout: WB_INTERCONNECT_TIMEOUT_EN.
module wb_interconnect
  import wb_pkg::*;
#(
  parameter int SLAVES         = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DECODE_LSB     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [ADDR_WIDTH-1:0]                        m_adr_i,
  input  logic [DATA_WIDTH-1:0]                        m_dat_i,
  input  logic                                         m_we_i,
  input  logic [DATA_WIDTH/8-1:0]                      m_sel_i,
  input  logic                                         m_stb_i,
  input  logic                                         m_cyc_i,
  output logic [DATA_WIDTH-1:0]                        m_dat_o,
  output logic                                         m_ack_o,
  output logic                                         m_err_o,
  input  logic [SLAVES-1:0][ADDR_WIDTH-DECODE_LSB-1:0] slave_base,
  output logic [ADDR_WIDTH-1:0]                        s_adr_o,
  output logic [DATA_WIDTH-1:0]                        s_dat_o,
  output logic                                         s_we_o,
  output logic [DATA_WIDTH/8-1:0]                      s_sel_o,
  output logic [SLAVES-1:0]                            s_cyc_o,
  output logic [SLAVES-1:0]                            s_stb_o,
  input  logic [SLAVES-1:0][DATA_WIDTH-1:0]            s_dat_i,
  input  logic [SLAVES-1:0]                            s_ack_i
);

  localparam int BASE_WIDTH = ADDR_WIDTH - DECODE_LSB;
  localparam int IDX_WIDTH  = clog2(SLAVES);

  wb_state_t              state, state_next;
  logic                   dec_hit;
  logic [IDX_WIDTH-1:0]   dec_idx, sel_idx;
  logic [SLAVES-1:0]      dec_onehot, strobe;
  logic                   accept, finish_ack, finish_err, timeout_hit;
  logic                   slave_ack;

  wb_addr_decoder #(
    .SLAVES     (SLAVES),
    .BASE_WIDTH (BASE_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_decoder (
    .page       (m_adr_i[ADDR_WIDTH-1:DECODE_LSB]),
    .slave_base (slave_base),
    .hit        (dec_hit),
    .idx        (dec_idx)
  );

  always_comb begin
    dec_onehot = '0;
    for (int i = 0; i < SLAVES; i++) begin
      dec_onehot[i] = (dec_idx == IDX_WIDTH'(i));
    end
  end

  assign slave_ack = s_ack_i[sel_idx];
  assign s_cyc_o   = strobe;
  assign s_stb_o   = strobe;

`ifdef WB_INTERCONNECT_TIMEOUT_EN
  logic [15:0] busy_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt <= '0;
    end else if (accept) begin
      busy_cnt <= '0;
    end else if (state == BUSY) begin
      busy_cnt <= busy_cnt + 16'd1;
    end
  end

  // Fires in the BUSY cycle that brings the count up to the limit.
  assign timeout_hit = (state == BUSY) && ((busy_cnt + 16'd1) == 16'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  // Abort by the master takes precedence; an ack beats a coincident timeout.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish_ack = 1'b0;
    finish_err = 1'b0;
    case (state)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          if (dec_hit) begin
            accept     = 1'b1;
            state_next = BUSY;
          end else begin
            finish_err = 1'b1;
            state_next = DONE;
          end
        end
      end
      BUSY: begin
        if (!m_cyc_i) begin
          state_next = IDLE;
        end else if (slave_ack) begin
          finish_ack = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          finish_err = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      strobe  <= '0;
      sel_idx <= '0;
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      m_dat_o <= '0;
      s_adr_o <= '0;
      s_dat_o <= '0;
      s_we_o  <= 1'b0;
      s_sel_o <= '0;
    end else begin
      state   <= state_next;
      m_ack_o <= finish_ack;
      m_err_o <= finish_err;
      if (accept) begin
        s_adr_o <= m_adr_i;
        s_dat_o <= m_dat_i;
        s_we_o  <= m_we_i;
        s_sel_o <= m_sel_i;
        sel_idx <= dec_idx;
        strobe  <= dec_onehot;
      end else if (state_next != BUSY) begin
        strobe <= '0;
      end
      // Writes keep the last read value on m_dat_o.
      if (finish_ack && !s_we_o) begin
        m_dat_o <= s_dat_i[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Self-checking bench for wb_interconnect: a transaction-level model expands
// each request into expected per-cycle outputs that a compare process checks.
module tb_wb_interconnect;

  localparam int SLAVES = 2;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int LSB    = 8;
  localparam int TMO    = 4;
  localparam int BW     = AW - LSB;
`ifdef WB_INTERCONNECT_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         rst = 1'b0;
  logic [AW-1:0]                m_adr_i = '0;
  logic [DW-1:0]                m_dat_i = '0;
  logic                         m_we_i  = 1'b0;
  logic [3:0]                   m_sel_i = '0;
  logic                         m_stb_i = 1'b0;
  logic                         m_cyc_i = 1'b0;
  logic [DW-1:0]                m_dat_o;
  logic                         m_ack_o, m_err_o;
  logic [SLAVES-1:0][BW-1:0]    slave_base = '0;
  logic [AW-1:0]                s_adr_o;
  logic [DW-1:0]                s_dat_o;
  logic                         s_we_o;
  logic [3:0]                   s_sel_o;
  logic [SLAVES-1:0]            s_cyc_o, s_stb_o;
  logic [SLAVES-1:0][DW-1:0]    s_dat_i = '0;
  logic [SLAVES-1:0]            s_ack_i = '0;

  always #5 clk = ~clk;

  wb_interconnect #(
    .SLAVES(SLAVES), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .DECODE_LSB(LSB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .slave_base(slave_base),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  typedef struct {
    logic [1:0]  stb;
    logic        ack;
    logic        err;
    logic [31:0] dat;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        we;
    logic [3:0]  sel;
  } exp_t;

  exp_t exp_q[$];
  exp_t idle_exp;
  int   total = 0;
  int   bad   = 0;
  int   ack_cnt = 0, err_cnt = 0, stb_cnt0 = 0, stb_cnt1 = 0;

  logic [31:0] mdl_dat = '0, mdl_adr = '0, mdl_wdat = '0;
  logic        mdl_we  = 1'b0;
  logic [3:0]  mdl_sel = '0;

  function automatic exp_t zeroExp();
    exp_t e;
    e.stb = '0; e.ack = 1'b0; e.err = 1'b0; e.dat = '0;
    e.adr = '0; e.wdat = '0; e.we = 1'b0; e.sel = '0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare process: one expected record per cycle while a transaction runs,
  // otherwise the held idle values.
  initial idle_exp = zeroExp();
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      e = zeroExp();
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      idle_exp = e;
      idle_exp.stb = '0;
      idle_exp.ack = 1'b0;
      idle_exp.err = 1'b0;
    end else begin
      e = idle_exp;
    end
    checkOutput("s_stb_o", s_stb_o, e.stb);
    checkOutput("s_cyc_o", s_cyc_o, e.stb);
    checkOutput("m_ack_o", m_ack_o, e.ack);
    checkOutput("m_err_o", m_err_o, e.err);
    checkOutput("m_dat_o", m_dat_o, e.dat);
    checkOutput("s_adr_o", s_adr_o, e.adr);
    checkOutput("s_dat_o", s_dat_o, e.wdat);
    checkOutput("s_we_o",  s_we_o,  e.we);
    checkOutput("s_sel_o", s_sel_o, e.sel);
    if (m_ack_o)    ack_cnt++;
    if (m_err_o)    err_cnt++;
    if (s_stb_o[0]) stb_cnt0++;
    if (s_stb_o[1]) stb_cnt1++;
  end

  function automatic int decodeSlave(input logic [31:0] adr);
    for (int i = 0; i < SLAVES; i++) begin
      if (adr[31:8] == slave_base[i]) return i;
    end
    return -1;
  endfunction

  task automatic clearCounts();
    ack_cnt = 0; err_cnt = 0; stb_cnt0 = 0; stb_cnt1 = 0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ack_delay: BUSY cycle (1-based) in which the slave acks, 0 = never.
  // abort_at: BUSY cycle in which the master drops m_cyc_i, 0 = never.
  task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] wdat,
                               input logic we, input logic [3:0] sel,
                               input int ack_delay, input int abort_at,
                               input logic [31:0] rdata, input bit stray);
    exp_t       e;
    int         idx, n_stb, n_cyc;
    bit         is_ack, is_err;
    logic [1:0] oh;
    idx = decodeSlave(adr);
    e.stb = '0; e.ack = 1'b0; e.err = 1'b0; e.dat = mdl_dat;
    e.adr = mdl_adr; e.wdat = mdl_wdat; e.we = mdl_we; e.sel = mdl_sel;
    exp_q.push_back(e);
    is_ack = 1'b0; is_err = 1'b0; n_stb = 0; oh = '0;
    if (idx < 0) is_err = 1'b1;
    else if (abort_at > 0) n_stb = abort_at;
    else if (TMO_ON && (ack_delay == 0 || ack_delay > TMO)) begin
      n_stb = TMO; is_err = 1'b1;
    end else begin
      n_stb = ack_delay; is_ack = 1'b1;
    end
    if (idx >= 0) begin
      mdl_adr = adr; mdl_wdat = wdat; mdl_we = we; mdl_sel = sel;
      oh = 2'b01 << idx;
    end
    e.adr = mdl_adr; e.wdat = mdl_wdat; e.we = mdl_we; e.sel = mdl_sel;
    for (int k = 1; k <= n_stb; k++) begin
      e.stb = oh;
      exp_q.push_back(e);
    end
    if (is_ack || is_err) begin
      if (is_ack && !we) mdl_dat = rdata;
      e.stb = '0; e.ack = is_ack; e.err = is_err; e.dat = mdl_dat;
      exp_q.push_back(e);
    end
    n_cyc = 1 + n_stb + ((is_ack || is_err) ? 1 : 0);

    m_adr_i = adr; m_dat_i = wdat; m_we_i = we; m_sel_i = sel;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    for (int k = 1; k < n_cyc; k++) begin
      @(posedge clk);
      #1;
      s_ack_i = '0;
      s_dat_i = '0;
      if (is_ack && k == ack_delay) begin
        s_ack_i[idx] = 1'b1;
        s_dat_i[idx] = rdata;
      end
      if (stray && k == 1 && idx >= 0) begin
        s_ack_i[1-idx] = 1'b1;
        s_dat_i[1-idx] = 32'h5A5A_A5A5;
      end
      if (abort_at > 0 && k == abort_at) begin
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    s_ack_i = '0; s_dat_i = '0;
  endtask

  task automatic resetModel();
    exp_q.delete();
    idle_exp = zeroExp();
    mdl_dat = '0; mdl_adr = '0; mdl_wdat = '0; mdl_we = 1'b0; mdl_sel = '0;
  endtask

  // Starts a read to slave 1 and pulls reset while the strobe is up.
  task automatic resetMidBusy();
    exp_t e;
    e.stb = '0; e.ack = 1'b0; e.err = 1'b0; e.dat = mdl_dat;
    e.adr = mdl_adr; e.wdat = mdl_wdat; e.we = mdl_we; e.sel = mdl_sel;
    exp_q.push_back(e);
    e.stb = 2'b10; e.adr = 32'h0000_0108; e.wdat = 32'h0; e.we = 1'b0; e.sel = 4'hF;
    exp_q.push_back(e);
    m_adr_i = 32'h0000_0108; m_dat_i = '0; m_we_i = 1'b0; m_sel_i = 4'hF;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    resetModel();
    rst = 1'b0;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    #1;
    checkOutput("rst busy s_stb_o", s_stb_o, 2'b00);
    checkOutput("rst busy s_cyc_o", s_cyc_o, 2'b00);
    checkOutput("rst busy s_adr_o", s_adr_o, 32'h0);
    checkOutput("rst busy s_sel_o", s_sel_o, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    idleCycles(3);
    checkOutput("reset m_dat_o", m_dat_o, 32'h0);
    checkOutput("reset s_stb_o", s_stb_o, 2'b00);
    checkOutput("reset m_ack_o", m_ack_o, 1'b0);
    checkOutput("reset m_err_o", m_err_o, 1'b0);
    rst = 1'b1;
    slave_base[0] = 24'h000000;
    slave_base[1] = 24'h000001;
    idleCycles(2);

    $display("[TB] read slave1 with stray ack from slave0");
    clearCounts();
    applyStimulus(32'h0000_0104, 32'h0, 1'b0, 4'hF, 2, 0, 32'hDEAD_BEEF, 1'b1);
    idleCycles(2);
    checkOutput("rd1 m_dat_o", m_dat_o, 32'hDEAD_BEEF);
    checkOutput("rd1 ack pulses", ack_cnt, 1);
    checkOutput("rd1 stb1 cycles", stb_cnt1, 2);
    checkOutput("rd1 stb0 cycles", stb_cnt0, 0);

    $display("[TB] write slave0");
    clearCounts();
    applyStimulus(32'h0000_0010, 32'h1234_5678, 1'b1, 4'hF, 1, 0, 32'hBAD0_BAD0, 1'b0);
    idleCycles(2);
    checkOutput("wr m_dat_o held", m_dat_o, 32'hDEAD_BEEF);
    checkOutput("wr ack pulses", ack_cnt, 1);
    checkOutput("wr stb0 cycles", stb_cnt0, 1);
    checkOutput("wr s_dat_o", s_dat_o, 32'h1234_5678);
    checkOutput("wr s_we_o", s_we_o, 1'b1);

    $display("[TB] unmapped access");
    clearCounts();
    applyStimulus(32'h0000_0500, 32'h0, 1'b0, 4'hF, 1, 0, 32'h0, 1'b0);
    idleCycles(2);
    checkOutput("nomatch err pulses", err_cnt, 1);
    checkOutput("nomatch ack pulses", ack_cnt, 0);
    checkOutput("nomatch stb cycles", stb_cnt0 + stb_cnt1, 0);
    checkOutput("nomatch m_dat_o", m_dat_o, 32'hDEAD_BEEF);

    $display("[TB] partial-sel read slave0");
    clearCounts();
    applyStimulus(32'h0000_0020, 32'h0, 1'b0, 4'h3, 3, 0, 32'hCAFE_F00D, 1'b0);
    idleCycles(1);
    checkOutput("rd0 m_dat_o", m_dat_o, 32'hCAFE_F00D);
    checkOutput("rd0 stb0 cycles", stb_cnt0, 3);

    $display("[TB] overlapping bases");
    slave_base[1] = 24'h000000;
    clearCounts();
    applyStimulus(32'h0000_0020, 32'h0, 1'b0, 4'hF, 1, 0, 32'h0BAD_CAFE, 1'b0);
    idleCycles(1);
    checkOutput("ovl stb0 cycles", stb_cnt0, 1);
    checkOutput("ovl stb1 cycles", stb_cnt1, 0);
    checkOutput("ovl m_dat_o", m_dat_o, 32'h0BAD_CAFE);
    clearCounts();
    applyStimulus(32'h0000_0020, 32'h0, 1'b0, 4'hF, 0, 2, 32'h0, 1'b0);
    idleCycles(3);
    checkOutput("abort ack pulses", ack_cnt, 0);
    checkOutput("abort err pulses", err_cnt, 0);
    checkOutput("abort stb0 cycles", stb_cnt0, 2);
    slave_base[1] = 24'h000001;

    if (TMO_ON) begin
      $display("[TB] timeout with silent slave");
      clearCounts();
      applyStimulus(32'h0000_0040, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0, 1'b1);
      idleCycles(2);
      checkOutput("tmo err pulses", err_cnt, 1);
      checkOutput("tmo stb0 cycles", stb_cnt0, 4);
      clearCounts();
      applyStimulus(32'h0000_0040, 32'h0, 1'b0, 4'hF, 4, 0, 32'h1357_9BDF, 1'b0);
      idleCycles(2);
      checkOutput("tmo-ack ack pulses", ack_cnt, 1);
      checkOutput("tmo-ack err pulses", err_cnt, 0);
      checkOutput("tmo-ack m_dat_o", m_dat_o, 32'h1357_9BDF);
    end else begin
      $display("[TB] slow slave without timeout");
      clearCounts();
      applyStimulus(32'h0000_0040, 32'h0, 1'b0, 4'hF, 10, 0, 32'h1357_9BDF, 1'b0);
      idleCycles(2);
      checkOutput("slow ack pulses", ack_cnt, 1);
      checkOutput("slow stb0 cycles", stb_cnt0, 10);
      checkOutput("slow m_dat_o", m_dat_o, 32'h1357_9BDF);
    end

    $display("[TB] reset during BUSY");
    clearCounts();
    resetMidBusy();
    idleCycles(3);
    checkOutput("rst ack pulses", ack_cnt, 0);
    checkOutput("rst err pulses", err_cnt, 0);
    checkOutput("rst m_dat_o", m_dat_o, 32'h0);
    clearCounts();
    applyStimulus(32'h0000_0108, 32'h0, 1'b0, 4'hF, 1, 0, 32'h600D_F00D, 1'b0);
    idleCycles(2);
    checkOutput("post-rst m_dat_o", m_dat_o, 32'h600D_F00D);
    checkOutput("post-rst ack pulses", ack_cnt, 1);
    checkOutput("post-rst stb1 cycles", stb_cnt1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
